// File: rtl/ddr_burst_mem.sv
// ---------------------------------------------------------------------------
// ddr_burst_mem
//   Clocked memory model for the buffer datapath. It serves one burst request
//   at a time. A write burst stores byte-enabled beats. A read burst streams
//   beats back through a fixed-latency pipeline. Addresses wrap modulo 2**AW.
//
// Handshake semantics (all handshakes in this block):
//   A transfer happens on a rising clk edge where both valid and ready are
//   high. A valid that is dropped before that edge transfers nothing. The
//   read stream has no ready: rd_valid marks a beat the consumer must take.
//
// Ports
//   clk, rstn         rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = write burst, 0 = read burst
//   req_addr, req_len start word address, beats minus one
//   wr_valid/ready    write-beat handshake (ready only in WRITE)
//   wr_data, wr_be    write beat data and per-byte enables
//   rd_valid, rd_data read beat stream; rd_data holds while rd_valid is low
//   rd_last           final beat of the read burst
//   busy              high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module ddr_burst_mem #(
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_be,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              rd_last,
    output logic              busy
);

    localparam int BW = DW / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;

    logic [DW-1:0]    mem [0:(1<<AW)-1];

    // Read pipeline: stage 0 captures the array word, the last stage drives
    // the read outputs, so a beat whose address is presented in the cycle
    // after edge N reaches rd_valid on edge N+RD_LAT.
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] pl;
    logic [DW-1:0]     pd [RD_LAT];

    logic wr_fire;
    logic rd_issue;
    logic last_beat;

    assign wr_fire   = (state == S_WRITE) && wr_valid;
    assign rd_issue  = (state == S_READ);
    assign last_beat = (cnt == len);

    assign req_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WRITE);
    assign busy      = (state != S_IDLE);

    assign rd_valid  = pv[RD_LAT-1];
    assign rd_last   = pl[RD_LAT-1];
    assign rd_data   = pd[RD_LAT-1];

    // Burst sequencing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            addr  <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= req_we ? S_WRITE : S_READ;
                        addr  <= req_addr;
                        len   <= req_len;
                        cnt   <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt + 1'b1;
                        if (last_beat) state <= S_IDLE;
                    end
                end
                S_READ: begin
                    addr <= addr + 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (last_beat) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The final beat is on the outputs this cycle; it leaves
                    // the pipeline on the same edge the FSM returns to IDLE.
                    if (pl[RD_LAT-1]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage array: not reset, disabled bytes keep their old contents
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < BW; b++) begin
                if (wr_be[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read pipeline. Data stages only load when a valid beat moves in, so
    // the output stage holds its last beat while rd_valid is low. Reset
    // empties the pipeline, discarding any in-flight beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            pl <= '0;
            for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
        end else begin
            pv[0] <= rd_issue;
            pl[0] <= rd_issue && last_beat;
            if (rd_issue) pd[0] <= mem[addr];
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ddr_burst_mem.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_mem
//   Scoreboarded bench for ddr_burst_mem. Driver tasks issue bursts and keep
//   a word-array reference model; read requests push the expected beats
//   (data, last flag, arrival cycle) into queues, and a monitor on the
//   falling edge pops and compares whenever rd_valid is high.
// ---------------------------------------------------------------------------
module tb_ddr_burst_mem;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int LEN_W  = 4;
    localparam int RD_LAT = 2;
    localparam int BW     = DW / 8;
    localparam int DEPTH  = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic [BW-1:0]     wr_be;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rd_last;
    logic              busy;

    ddr_burst_mem #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            exp_cyc_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Per-beat stimulus for the next write burst
    logic [DW-1:0] wdat [16];
    logic [BW-1:0] wbe  [16];
    int            wgap [16];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn && rd_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got data %h last %b, expected no beat (cycle %0d)",
                         rd_data, rd_last, cyc);
            end else begin
                logic [DW-1:0] d;
                logic          l;
                int            c;
                d = exp_q.pop_front();
                l = exp_last_q.pop_front();
                c = exp_cyc_q.pop_front();
                if (rd_data !== d || rd_last !== l || cyc != c) begin
                    n_fail++;
                    $display("FAIL rd_beat: got data %h last %b cycle %0d, expected data %h last %b cycle %0d",
                             rd_data, rd_last, cyc, d, l, c);
                end
            end
        end
    end

    // ---------------- driver tasks (called just after a rising edge) ----------------
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [LEN_W-1:0] l,
                          output int acc);
        int t;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_len   = l;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_accept: got req_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
        int acc;
        logic [AW-1:0] wa;
        do_req(1'b1, a, l, acc);
        chk("wr_busy", {31'd0, busy}, 1);
        chk("wr_req_ready", {31'd0, req_ready}, 0);
        for (int b = 0; b <= int'(l); b++) begin
            for (int g = 0; g < wgap[b]; g++) begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
                @(posedge clk); #1;
                chk("gap_busy", {31'd0, busy}, 1);
                chk("gap_req_ready", {31'd0, req_ready}, 0);
            end
            chk("wr_ready", {31'd0, wr_ready}, 1);
            wr_valid = 1'b1;
            wr_data  = wdat[b];
            wr_be    = wbe[b];
            @(posedge clk); #1;
            wa = a + AW'(b);
            ref_write(wa, wdat[b], wbe[b]);
            wr_valid = 1'b0;
        end
        chk("wr_done_busy", {31'd0, busy}, 0);
        chk("wr_done_req_ready", {31'd0, req_ready}, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
        int acc;
        int t;
        logic [AW-1:0] ra;
        do_req(1'b0, a, l, acc);
        for (int b = 0; b <= int'(l); b++) begin
            ra = a + AW'(b);
            exp_q.push_back(ref_mem[ra]);
            exp_last_q.push_back(b == int'(l));
            exp_cyc_q.push_back(acc + RD_LAT + b);
        end
        chk("rd_req_ready", {31'd0, req_ready}, 0);
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
            exp_last_q.delete();
            exp_cyc_q.delete();
        end
        chk("rd_done_req_ready", {31'd0, req_ready}, 1);
        chk("rd_done_busy", {31'd0, busy}, 0);
    endtask

    task automatic no_gaps();
        for (int i = 0; i < 16; i++) wgap[i] = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_be     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", {31'd0, rd_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value so random reads are fully defined
        no_gaps();
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                wdat[i] = $urandom;
                wbe[i]  = '1;
            end
            do_write(AW'(k * 16), 4'd15);
        end
        do_read(8'h00, 4'd15);
        do_read(8'hF0, 4'd15);

        // Single-beat write and read back
        wdat[0] = 32'hA5A5_0001; wbe[0] = 4'hF;
        do_write(8'h10, 4'd0);
        do_read(8'h10, 4'd0);

        // Four-beat burst
        for (int i = 0; i < 4; i++) begin
            wdat[i] = DW'(i + 1);
            wbe[i]  = 4'hF;
        end
        do_write(8'h20, 4'd3);
        do_read(8'h20, 4'd3);

        // Partial byte enables over an all-ones word
        wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
        do_write(8'h30, 4'd0);
        wdat[0] = 32'h1234_5678; wbe[0] = 4'b0101;
        do_write(8'h30, 4'd0);
        do_read(8'h30, 4'd0);

        // Burst wrapping past the top of the array
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hC0DE_0000 + DW'(i);
            wbe[i]  = 4'hF;
        end
        do_write(8'hFE, 4'd3);
        do_read(8'hFE, 4'd3);
        do_read(8'hFC, 4'd7);

        // Gapped write beats: pattern 1,0,0,1,0,1 on wr_valid
        for (int i = 0; i < 3; i++) begin
            wdat[i] = 32'h5A00_0000 + DW'(i);
            wbe[i]  = 4'hF;
        end
        wgap[0] = 0; wgap[1] = 2; wgap[2] = 1;
        do_write(8'h40, 4'd2);
        no_gaps();
        do_read(8'h40, 4'd3);

        // Reset one cycle into a long read: nothing may come out
        do_req(1'b0, 8'h50, 4'd7, acc);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst_rd_valid", {31'd0, rd_valid}, 0);
        chk("midrst_req_ready", {31'd0, req_ready}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("postrst_req_ready", {31'd0, req_ready}, 1);
        chk("postrst_busy", {31'd0, busy}, 0);
        do_read(8'h50, 4'd7);

        // Random mix of bursts
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0]    a;
            logic [LEN_W-1:0] l;
            a = AW'($urandom_range(0, DEPTH - 1));
            l = LEN_W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wdat[i] = $urandom;
                    wbe[i]  = BW'($urandom_range(0, (1 << BW) - 1));
                    wgap[i] = $urandom_range(0, 2);
                end
                do_write(a, l);
            end else begin
                do_read(a, l);
            end
        end
        no_gaps();

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", DW'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
